seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan.sv | 112 +++++++++++
 tb/tb_seg_scan.sv | 124 ++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// seg_scan: four-digit multiplexed 7-segment scanner.
//   Walks the digits right to left (0,1,2,3), spending REFRESH_DIV clocks on each
//   one. The first GUARD clocks of every slot keep all anodes off so the previous
//   digit's segments cannot ghost onto the next anode. The BCD digits and decimal
//   points are captured once per frame, so one frame never mixes two input values.
//   Leading zeros can be blanked, and digit 0 is never blanked.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   digits_in  four BCD digits; [3:0] is digit 0 (rightmost)
//   dp_in      decimal-point request per digit, active-high
//   blank_lz   leading-zero blanking enable (used live, not captured)
//   duan_ctrl  digit code to the segment decoder; 4'hF means blank
//   wei_out    anode enables, active-low, bit k drives digit k
//   dp_out     decimal-point segment, active-low
module seg_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  duan_ctrl,
  output logic [3:0]  wei_out,
  output logic        dp_out
);
  localparam int NUM_DIGITS = 4;
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

  logic [CW-1:0]           cnt;
  logic [1:0]              idx;
  logic [15:0]             snap_d;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic                    term;

  assign term = (cnt == TERM);

  // Slot counter and digit index. The snapshot is taken on the last clock of
  // digit 3, so the new value is in place when digit 0 of the next frame starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= 2'd0;
      snap_d  <= 16'h0000;
      snap_dp <= 4'h0;
    end else begin
      cnt <= term ? '0 : cnt + 1'b1;
      if (term) idx <= idx + 2'd1;
      if (term && idx == 2'd3) begin
        snap_d  <= digits_in;
        snap_dp <= dp_in;
      end
    end
  end

  // all_zero[k]: digit k and every digit above it are zero. Codes A-F count as
  // nonzero here, so they stop the blanking.
  logic [NUM_DIGITS-1:0] dig_zero, all_zero, blank;

  genvar k;
  generate
    for (k = 0; k < NUM_DIGITS; k++) begin : g_dig
      assign dig_zero[k] = (snap_d[4*k +: 4] == 4'h0);
      if (k == NUM_DIGITS - 1) begin : g_top
        assign all_zero[k] = dig_zero[k];
      end else begin : g_low
        assign all_zero[k] = dig_zero[k] & all_zero[k+1];
      end
      if (k == 0) begin : g_d0
        assign blank[k] = 1'b0;
      end else begin : g_dn
        assign blank[k] = blank_lz & all_zero[k];
      end
    end
  endgenerate

  logic [3:0] nxt_duan, nxt_wei, cur_d;
  logic       nxt_dp;

  assign cur_d = snap_d[{idx, 2'b00} +: 4];

  always_comb begin
    nxt_duan = 4'hF;
    nxt_wei  = 4'b1111;
    nxt_dp   = 1'b1;
    if (int'(cnt) >= GUARD) begin
      // The decimal point follows its digit even when the digit itself is blanked.
      nxt_dp = ~snap_dp[idx];
      if (!blank[idx]) begin
        nxt_duan = cur_d;
        nxt_wei  = ~(4'b0001 << idx);
      end
    end
  end

  // Registered outputs: one clock behind the counter and index that produced them.
  always_ff @(posedge clk) begin
    if (rst) begin
      duan_ctrl <= 4'hF;
      wei_out   <= 4'b1111;
      dp_out    <= 1'b1;
    end else begin
      duan_ctrl <= nxt_duan;
      wei_out   <= nxt_wei;
      dp_out    <= nxt_dp;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
module tb_seg_scan;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  duan_ctrl, wei_out;
  logic        dp_out;

  int checks = 0;
  int errors = 0;

  seg_scan #(.REFRESH_DIV(4), .GUARD(1)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .duan_ctrl(duan_ctrl), .wei_out(wei_out), .dp_out(dp_out)
  );

  always #5 clk = ~clk;

  // At most one anode may be enabled at any time.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ($countones(~wei_out) > 1) begin
        errors++;
        $display("FAIL onehot_anode: wei_out=%b, required at most one 0 bit", wei_out);
      end
    end
  end

  typedef struct {
    logic [15:0] d;
    logic [3:0]  dp;
    logic        blz;
    logic [15:0] exp_duan;   // shown code per digit (F where blanked)
    logic [3:0]  exp_blank;  // digits with anode off
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got wei=%b duan=%h dp=%b, required wei=%b duan=%h dp=%b",
               name, act[8:5], act[4:1], act[0], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  // Checks one whole frame (4 slots x 4 clocks), starting right after a frame
  // boundary. Optionally changes digits_in at the start of slot 1.
  task automatic check_frame(input string name, input logic [15:0] exp_duan,
                             input logic [3:0] exp_blank, input logic [3:0] exp_dp,
                             input logic chg, input logic [15:0] new_d);
    logic [8:0] e;
    logic [3:0] w;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        if (chg && s == 1 && c == 0) digits_in = new_d;
        step();
        if (c == 0) begin
          e = {4'b1111, 4'hF, 1'b1};
        end else if (exp_blank[s]) begin
          e = {4'b1111, 4'hF, ~exp_dp[s]};
        end else begin
          w = 4'b1111;
          w[s] = 1'b0;
          e = {w, exp_duan[4*s +: 4], ~exp_dp[s]};
        end
        cmp($sformatf("%s s%0d c%0d", name, s, c), {wei_out, duan_ctrl, dp_out}, e);
      end
    end
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, 16'h1234, 4'b0000};
    vecs[1] = '{16'h0050, 4'b0000, 1'b1, 16'hFF50, 4'b1100};
    vecs[2] = '{16'h0050, 4'b0000, 1'b0, 16'h0050, 4'b0000};
    vecs[3] = '{16'h0000, 4'b0100, 1'b1, 16'hFFF0, 4'b1110};
    vecs[4] = '{16'h00A0, 4'b1001, 1'b1, 16'hFFA0, 4'b1100};
    vecs[5] = '{16'h0007, 4'b0000, 1'b1, 16'hFFF7, 4'b1110};
    vecs[6] = '{16'h1000, 4'b0010, 1'b1, 16'h1000, 4'b0000};

    rst = 1'b1; digits_in = 16'h1234; dp_in = 4'h0; blank_lz = 1'b0;
    step();
    cmp("reset_state", {wei_out, duan_ctrl, dp_out}, {4'b1111, 4'hF, 1'b1});
    rst = 1'b0;

    // First frame after reset shows the cleared snapshot.
    check_frame("post_reset_0000", 16'h0000, 4'b0000, 4'b0000, 1'b0, 16'h0);

    for (int i = 0; i < 7; i++) begin
      digits_in = vecs[i].d; dp_in = vecs[i].dp; blank_lz = vecs[i].blz;
      for (int c = 0; c < 16; c++) step();  // frame that captures the inputs
      check_frame($sformatf("vec%0d", i), vecs[i].exp_duan, vecs[i].exp_blank,
                  vecs[i].dp, 1'b0, 16'h0);
    end

    // Mid-frame input change is held off until the next frame boundary.
    digits_in = 16'h1111; dp_in = 4'h0; blank_lz = 1'b0;
    for (int c = 0; c < 16; c++) step();
    check_frame("coherent_old", 16'h1111, 4'b0000, 4'b0000, 1'b1, 16'h2222);
    check_frame("coherent_new", 16'h2222, 4'b0000, 4'b0000, 1'b0, 16'h0);

    // Reset in the middle of slot 2, while digit 2 is being displayed.
    digits_in = 16'h1234;
    for (int c = 0; c < 10; c++) step();
    cmp("pre_reset_slot2", {wei_out, duan_ctrl, dp_out}, {4'b1011, 4'h2, 1'b1});
    rst = 1'b1;
    step();
    cmp("mid_reset", {wei_out, duan_ctrl, dp_out}, {4'b1111, 4'hF, 1'b1});
    rst = 1'b0;
    check_frame("restart_0000", 16'h0000, 4'b0000, 4'b0000, 1'b0, 16'h0);
    check_frame("restart_1234", 16'h1234, 4'b0000, 4'b0000, 1'b0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
